// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_buf
//  Purpose  : Parametrised inter-stage pipeline buffer carrying a PC and an
//             instruction word over a valid/ready handshake with backpressure.
//             All state updates on the falling clock edge.
//             Reset is asynchronous and active-low.
//  Options  : PIPE_BUF_SKID_EN
//             - defined:   two-entry skid buffer with registered i_ready
//             - undefined: single entry with combinational i_ready
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [INSTR_W-1:0] i_instruction,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [PC_W-1:0]    o_pc,
  output logic [INSTR_W-1:0] o_instruction
);

`ifdef PIPE_BUF_SKID_EN
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    ONE   = 1'b1
  } state_t;
`endif

  state_t             state;
  state_t             state_nxt;
  logic [PC_W-1:0]    main_pc;
  logic [INSTR_W-1:0] main_instr;
  logic               load_main_in;
  logic               accept;
  logic               consume;

`ifdef PIPE_BUF_SKID_EN
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic               load_skid;
  logic               load_main_skid;
`endif

  assign o_valid       = (state != EMPTY);
  assign o_pc          = main_pc;
  assign o_instruction = o_valid ? main_instr : NOP_INSTR;

`ifdef PIPE_BUF_SKID_EN
  // Skid occupancy is the FULL state, so i_ready comes straight from a register.
  assign i_ready = (state != FULL);
`else
  // Without a skid entry the buffer can only take a word if the held one leaves.
  assign i_ready = ~o_valid | o_ready;
`endif

  assign accept  = i_valid & i_ready;
  assign consume = o_valid & o_ready;

  // Next-state and data-load selection; flush overrides every transition.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
`ifdef PIPE_BUF_SKID_EN
    load_skid      = 1'b0;
    load_main_skid = 1'b0;
`endif
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_main_in = 1'b1;
`ifdef PIPE_BUF_SKID_EN
          end else if (accept) begin
            state_nxt = FULL;
            load_skid = 1'b1;
`endif
          end else if (consume) begin
            state_nxt = EMPTY;
          end
        end
`ifdef PIPE_BUF_SKID_EN
        FULL: begin
          if (consume) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
`endif
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // State register, cleared asynchronously by reset.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  // Main entry: loads from the input or is refilled from the skid entry.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      main_pc    <= '0;
      main_instr <= NOP_INSTR;
    end else if (load_main_in) begin
      main_pc    <= i_pc;
      main_instr <= i_instruction;
`ifdef PIPE_BUF_SKID_EN
    end else if (load_main_skid) begin
      main_pc    <= skid_pc;
      main_instr <= skid_instr;
`endif
    end
  end

`ifdef PIPE_BUF_SKID_EN
  // Skid entry captures the one word accepted after downstream stalls.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      skid_pc    <= '0;
      skid_instr <= NOP_INSTR;
    end else if (load_skid) begin
      skid_pc    <= i_pc;
      skid_instr <= i_instruction;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
module tb_pipe_stage_buf;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_pc;
  logic [31:0] i_instruction;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_pc;
  logic [31:0] o_instruction;

  int passed = 0;
  int total  = 0;

  pipe_stage_buf #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(32'h0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_valid(i_valid), .i_ready(i_ready), .i_pc(i_pc), .i_instruction(i_instruction),
    .o_valid(o_valid), .o_ready(o_ready), .o_pc(o_pc), .o_instruction(o_instruction)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        ex_irdy;  // i_ready with these inputs, before the edge
    logic        ex_ov;    // o_valid after the edge
    logic [31:0] ex_pc;    // o_pc after the edge
  } vec_t;

  vec_t vecs[16];
  int   nv;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] pc, input logic ordy);
    flush         = fl;
    i_valid       = iv;
    i_pc          = pc;
    i_instruction = instr_of(pc);
    o_ready       = ordy;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_o_valid"}, {31'b0, o_valid}, 32'd0);
    chk({tag, "_o_pc"}, o_pc, 32'd0);
    chk({tag, "_o_instr"}, o_instruction, 32'd0);
    chk({tag, "_i_ready"}, {31'b0, i_ready}, 32'd1);
  endtask

  task automatic randomize_inputs();
    flush         = 1'($urandom);
    i_valid       = 1'($urandom);
    o_ready       = 1'($urandom);
    i_pc          = $urandom;
    i_instruction = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);

`ifdef PIPE_BUF_SKID_EN
    nv = 16;
    vecs[0]  = '{1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 32'h100};
    vecs[1]  = '{1'b0, 1'b1, 32'h104, 1'b1, 1'b1, 1'b1, 32'h104};
    vecs[2]  = '{1'b0, 1'b1, 32'h108, 1'b1, 1'b1, 1'b1, 32'h108};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h108};
    vecs[4]  = '{1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h200};
    vecs[5]  = '{1'b0, 1'b1, 32'h204, 1'b0, 1'b1, 1'b1, 32'h200};
    vecs[6]  = '{1'b0, 1'b1, 32'h208, 1'b0, 1'b0, 1'b1, 32'h200};
    vecs[7]  = '{1'b0, 1'b1, 32'h208, 1'b1, 1'b0, 1'b1, 32'h204};
    vecs[8]  = '{1'b0, 1'b1, 32'h208, 1'b1, 1'b1, 1'b1, 32'h208};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h208};
    vecs[10] = '{1'b0, 1'b1, 32'h210, 1'b0, 1'b1, 1'b1, 32'h210};
    vecs[11] = '{1'b0, 1'b1, 32'h214, 1'b0, 1'b1, 1'b1, 32'h210};
    vecs[12] = '{1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h210};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h210};
    vecs[14] = '{1'b0, 1'b1, 32'h220, 1'b1, 1'b1, 1'b1, 32'h220};
    vecs[15] = '{1'b1, 1'b1, 32'h224, 1'b1, 1'b1, 1'b0, 32'h220};
`else
    nv = 15;
    vecs[0]  = '{1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 32'h100};
    vecs[1]  = '{1'b0, 1'b1, 32'h104, 1'b1, 1'b1, 1'b1, 32'h104};
    vecs[2]  = '{1'b0, 1'b1, 32'h108, 1'b1, 1'b1, 1'b1, 32'h108};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h108};
    vecs[4]  = '{1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h200};
    vecs[5]  = '{1'b0, 1'b1, 32'h204, 1'b0, 1'b0, 1'b1, 32'h200};
    vecs[6]  = '{1'b0, 1'b1, 32'h204, 1'b1, 1'b1, 1'b1, 32'h204};
    vecs[7]  = '{1'b0, 1'b1, 32'h208, 1'b1, 1'b1, 1'b1, 32'h208};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h208};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h208};
    vecs[10] = '{1'b0, 1'b1, 32'h210, 1'b0, 1'b1, 1'b1, 32'h210};
    vecs[11] = '{1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h210};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h210};
    vecs[13] = '{1'b0, 1'b1, 32'h220, 1'b1, 1'b1, 1'b1, 32'h220};
    vecs[14] = '{1'b1, 1'b1, 32'h224, 1'b1, 1'b1, 1'b0, 32'h220};
`endif

    // Reset with random inputs: outputs clear with no clock edge, and stay so.
    #1;
    rst = 1'b0;
    randomize_inputs();
    #1;
    chk_reset("reset_async");
    for (int k = 0; k < 2; k++) begin
      step();
      randomize_inputs();
      #1;
      chk_reset("reset_hold");
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    rst = 1'b1;

    // Directed vector table.
    for (int i = 0; i < nv; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d_i_ready", i), {31'b0, i_ready}, {31'b0, vecs[i].ex_irdy});
      step();
      chk($sformatf("v%0d_o_valid", i), {31'b0, o_valid}, {31'b0, vecs[i].ex_ov});
      chk($sformatf("v%0d_o_pc", i), o_pc, vecs[i].ex_pc);
      chk($sformatf("v%0d_o_instr", i), o_instruction,
          vecs[i].ex_ov ? instr_of(vecs[i].ex_pc) : 32'h0);
    end

    // Asynchronous reset between edges while holding data.
    drive(1'b0, 1'b1, 32'h400, 1'b0);
    step();
    drive(1'b0, 1'b1, 32'h404, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("midrst_pre_valid", {31'b0, o_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset("midrst");
    #1;
    rst = 1'b1;
    drive(1'b0, 1'b1, 32'h500, 1'b1);
    #1;
    chk("post_rst_i_ready", {31'b0, i_ready}, 32'd1);
    step();
    chk("post_rst_o_valid", {31'b0, o_valid}, 32'd1);
    chk("post_rst_o_pc", o_pc, 32'h500);
    chk("post_rst_o_instr", o_instruction, instr_of(32'h500));
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    step();
    chk("drain_o_valid", {31'b0, o_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised inter-stage pipeline buffer, the successor to the team's fixed 32-bit fetch/decode latch. It carries a PC and instruction word between any two pipeline stages using a valid/ready handshake with backpressure. It provides a two-entry skid buffer so upstream never loses data when downstream stalls, and a flush input that injects a bubble. It is instantiated between fetch/decode, decode/execute and execute/memory.

## Interface
- PC_W, 32, width of the PC field
- INSTR_W, 32, width of the instruction field
- NOP_INSTR, {INSTR_W{1'b0}}, value driven on o_instruction whenever o_valid=0
- clk  in  1  clock; all state updates on the falling edge, matching the team's existing buffers
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  discard all held entries at the next falling edge
- i_valid  in  1  upstream presents a word
- i_ready  out  1  buffer accepts a word at this edge
- i_pc  in  PC_W  upstream PC
- i_instruction  in  INSTR_W  upstream instruction
- o_valid  out  1  output word is valid
- o_ready  in  1  downstream consumes the output word at this edge
- o_pc  out  PC_W  held PC
- o_instruction  out  INSTR_W  held instruction, or NOP_INSTR when o_valid=0

## Operation
- Storage:
  - main entry: drives the outputs.
  - skid entry: holds one overflow word.
- States:
  - EMPTY: main and skid both invalid.
  - ONE: main valid only.
  - FULL: main and skid both valid.
- Handshake definitions:
  - accept = i_valid & i_ready.
  - consume = o_valid & o_ready.
- i_ready = ~skid_valid. It is a registered signal, with no combinational path from o_ready.
- Transitions (flush=0):
  - EMPTY: accept → ONE (main ← input).
  - ONE:
    - accept & consume → ONE (main ← input).
    - accept & ~consume → FULL (skid ← input).
    - consume & ~accept → EMPTY.
  - FULL: consume → ONE (main ← skid). No accept is possible in FULL.
- In every other case the state and data are held.
- Flush has priority over everything:
  - The next falling edge forces EMPTY.
  - An input accepted at the same edge is discarded.
  - A consume at the same edge is still counted by downstream.
- o_instruction = NOP_INSTR while o_valid=0.
- o_pc holds its last value while o_valid=0.
- The word at o_pc/o_instruction is stable while o_valid=1 and o_ready=0.

## Timing
- Reset (rst=0, asynchronous):
  - o_valid=0, o_pc=0, o_instruction=NOP_INSTR.
  - Skid entry is invalid, so i_ready=1 while rst=0. No edges are required.
- Latency: a word accepted at falling edge N appears on o_* after edge N, when the buffer was EMPTY or ONE with a simultaneous consume.
- Throughput: one word per cycle while o_ready=1.
- Backpressure: after o_ready drops, at most one further word is accepted; i_ready is 0 one edge later.
- Recovery: the first edge with o_ready=1 in FULL moves skid→main, and i_ready returns to 1 after that edge.
- Reset asserted mid-operation clears all entries immediately.
- The first edge after rst deasserts behaves as EMPTY.

## Configuration
- PIPE_BUF_SKID_EN:
  - Defined: the two-entry skid behaviour described above, with registered i_ready.
  - Undefined: single main entry only, with no skid storage.
    - i_ready = ~o_valid | o_ready, a combinational path.
    - States are EMPTY and ONE only.
    - Flush, reset and NOP behaviour are unchanged.
    - Latency is unchanged.

## Test plan
- Reset: rst=0 with random inputs → o_valid=0, o_instruction=NOP_INSTR (0), o_pc=0, i_ready=1; hold across edges.
- Streaming: i_valid=1, o_ready=1, pc 0x100,0x104,0x108 → o_pc follows one edge later, o_valid continuous, no drops.
- Stall:
  - Stimulus: o_ready=0 while streaming 0x200,0x204,0x208.
  - Required response: 0x200 held in main, 0x204 in skid, i_ready=0, and 0x208 not accepted.
  - Release o_ready → order 0x200,0x204,0x208 delivered.
- Flush in FULL: flush=1 with i_valid=1 (pc 0x300) → next edge o_valid=0, o_instruction=NOP_INSTR, i_ready=1, 0x300 never appears.
- Async reset mid-stream: rst pulsed low between edges while FULL → outputs cleared immediately; first word after release reaches o_* in one edge.
- Config off (PIPE_BUF_SKID_EN undefined): o_ready=0 with o_valid=1 → i_ready=0 combinationally; o_ready=1 → i_ready=1 in the same cycle.
